mc_controller: RTL

//  Multicycle ARM-subset control unit: instruction-step FSM, decoder and conditional-execution logic in one block.

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_condunit.sv | 62 ++++++
 rtl/mc_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// ALU codes, instruction field codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Data-processing command field Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       legal;
    logic [2:0] alu;
    logic       no_write;
    logic       arith;
  } dp_dec_t;

endpackage

// File: rtl/mc_condunit.sv
// Condition unit: architectural NZCV flag register, condition evaluation
// against the stored flags, and the per-instruction CondQ latch.
module mc_condunit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_w,
  input  logic       i_cond_load,
  output logic       o_cond_q
);

  logic [3:0] r_flags;
  logic       r_cond_q;
  logic       w_cond_ex;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~w_c | w_z;
      COND_GE: w_cond_ex = (w_n == w_v);
      COND_LT: w_cond_ex = (w_n != w_v);
      COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: w_cond_ex = w_z | (w_n != w_v);
      COND_AL: w_cond_ex = 1'b1;
      COND_NV: w_cond_ex = 1'b0;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags  <= 4'b0000;
      r_cond_q <= 1'b0;
    end else begin
      if (i_flag_w[1]) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_w[0]) r_flags[1:0] <= i_alu_flags[1:0];
      if (i_cond_load) r_cond_q <= w_cond_ex;
    end
  end

  assign o_cond_q = r_cond_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: instruction-step FSM, Funct decoder,
// conditional-execution gating and illegal-instruction flagging.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W  = 3,
  parameter bit EN_EOR     = 1'b1,
  parameter bit EN_NOWRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal
);

  state_t     r_state;
  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unused_rn;
  dp_dec_t    w_dec;
  logic       w_illegal_instr;
  logic       w_cond_q;
  logic       w_s_flags;
  logic [1:0] w_flag_w;
  logic [2:0] w_alu;

  logic       w_fetch_pcw, w_adr_src, w_mem_w, w_ir_write, w_src_a;
  logic [1:0] w_res_src, w_src_b;
  logic       w_reg_w, w_branch, w_alu_op, w_cond_load, w_flag_upd, w_illegal;

  assign w_cond      = Instr[19:16];
  assign w_op        = Instr[15:14];
  assign w_funct     = Instr[13:8];
  assign w_rd        = Instr[3:0];
  assign w_unused_rn = ^Instr[7:4];

  always_comb begin
    w_dec = '{legal: 1'b1, alu: ALU_ADD, no_write: 1'b0, arith: 1'b0};
    case (w_funct[4:1])
      CMD_ADD: w_dec = '{legal: 1'b1, alu: ALU_ADD, no_write: 1'b0, arith: 1'b1};
      CMD_SUB: w_dec = '{legal: 1'b1, alu: ALU_SUB, no_write: 1'b0, arith: 1'b1};
      CMD_AND: w_dec = '{legal: 1'b1, alu: ALU_AND, no_write: 1'b0, arith: 1'b0};
      CMD_ORR: w_dec = '{legal: 1'b1, alu: ALU_ORR, no_write: 1'b0, arith: 1'b0};
      CMD_EOR: w_dec = '{legal: EN_EOR, alu: ALU_EOR, no_write: 1'b0, arith: 1'b0};
      CMD_CMP: w_dec = '{legal: EN_NOWRITE, alu: ALU_SUB, no_write: EN_NOWRITE, arith: 1'b1};
      CMD_TST: w_dec = '{legal: EN_NOWRITE, alu: ALU_AND, no_write: EN_NOWRITE, arith: 1'b0};
      default: w_dec = '{legal: 1'b0, alu: ALU_ADD, no_write: 1'b0, arith: 1'b0};
    endcase
  end

  assign w_illegal_instr = (w_op == OP_UNDEF) || ((w_op == OP_DP) && !w_dec.legal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_illegal_instr) begin
            r_state <= S_FETCH;
          end else begin
            case (w_op)
              OP_DP:   r_state <= w_funct[5] ? S_EXECI : S_EXECR;
              OP_MEM:  r_state <= S_MEMADR;
              OP_BR:   r_state <= S_BRANCH;
              default: r_state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:   r_state <= w_funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the current state; only FETCH also looks at MemReady.
  always_comb begin
    w_fetch_pcw = 1'b0;
    w_adr_src   = 1'b0;
    w_mem_w     = 1'b0;
    w_ir_write  = 1'b0;
    w_src_a     = 1'b0;
    w_res_src   = RES_ALUOUT;
    w_src_b     = SRCB_RD2;
    w_reg_w     = 1'b0;
    w_branch    = 1'b0;
    w_alu_op    = 1'b0;
    w_cond_load = 1'b0;
    w_flag_upd  = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write  = MemReady;
        w_fetch_pcw = MemReady;
        w_src_a     = 1'b1;
        w_src_b     = SRCB_FOUR;
        w_res_src   = RES_ALURESULT;
      end
      S_DECODE: begin
        w_src_a     = 1'b1;
        w_src_b     = SRCB_FOUR;
        w_res_src   = RES_ALURESULT;
        w_cond_load = 1'b1;
        w_illegal   = w_illegal_instr;
      end
      S_MEMADR:   w_src_b = SRCB_IMM;
      S_MEMREAD:  w_adr_src = 1'b1;
      S_MEMWB: begin
        w_res_src = RES_DATA;
        w_reg_w   = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      S_EXECR: begin
        w_src_b    = SRCB_RD2;
        w_alu_op   = 1'b1;
        w_flag_upd = 1'b1;
      end
      S_EXECI: begin
        w_src_b    = SRCB_IMM;
        w_alu_op   = 1'b1;
        w_flag_upd = 1'b1;
      end
      S_ALUWB: begin
        w_res_src = RES_ALUOUT;
        w_reg_w   = ~w_dec.no_write;
      end
      S_BRANCH: begin
        w_src_b   = SRCB_IMM;
        w_res_src = RES_ALURESULT;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // CMP/TST always set flags; C,V only follow arithmetic results.
  assign w_s_flags = w_flag_upd & (w_funct[0] | w_dec.no_write) & w_cond_q;
  assign w_flag_w  = {w_s_flags, w_s_flags & w_dec.arith};
  assign w_alu     = w_alu_op ? w_dec.alu : ALU_ADD;

  mc_condunit u_condunit (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (w_cond),
    .i_alu_flags (ALUFlags),
    .i_flag_w    (w_flag_w),
    .i_cond_load (w_cond_load),
    .o_cond_q    (w_cond_q)
  );

  // Outputs are forced low combinationally so an aborting reset cannot let
  // any write strobe through before the next clock edge.
  assign PCWrite    = reset & (w_fetch_pcw |
                               ((w_branch | (w_reg_w & (w_rd == 4'hF))) & w_cond_q));
  assign AdrSrc     = reset & w_adr_src;
  assign MemWrite   = reset & w_mem_w & w_cond_q;
  assign IRWrite    = reset & w_ir_write;
  assign ResultSrc  = reset ? w_res_src : 2'b00;
  assign ALUSrcA    = reset & w_src_a;
  assign ALUSrcB    = reset ? w_src_b : 2'b00;
  assign RegSrc     = reset ? {(w_op == OP_MEM) & ~w_funct[0], w_op == OP_BR} : 2'b00;
  assign RegWrite   = reset & w_reg_w & w_cond_q;
  assign ImmSrc     = reset ? w_op : 2'b00;
  assign ALUControl = reset ? ALUCTRL_W'(w_alu) : '0;
  assign Illegal    = reset & w_illegal;

endmodule
